// File: rtl/serial_shift_right_pkg.sv
// Shared constants and FSM encoding for the serial right shifter and the ALU-control decoder.
// Optional left-shift support is enabled by defining SERIAL_SHIFT_LEFT_EN.
package serial_shift_right_pkg;

    localparam int unsigned SHIFT_SIZE_DEF    = 32;
    localparam int unsigned SHIFT_SHAMT_W_DEF = $clog2(SHIFT_SIZE_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    // Bit shifted in at the MSB on a right step: sign for arithmetic, zero for logical.
    function automatic logic shift_fill(input logic arith, input logic msb);
        return arith & msb;
    endfunction

endpackage

// File: rtl/serial_shift_right_if.sv
// Start/done handshake and operand/result bus of the serial shifter.
// The dir_i signal exists only when SERIAL_SHIFT_LEFT_EN is defined.
interface serial_shift_right_if #(
    parameter int unsigned size    = 32,
    parameter int unsigned shamt_w = $clog2(size)
);
    logic               start_i;
    logic               arith_i;
`ifdef SERIAL_SHIFT_LEFT_EN
    logic               dir_i;
`endif
    logic [size-1:0]    data_i;
    logic [shamt_w-1:0] shamt_i;
    logic               busy_o;
    logic               done_o;
    logic [size-1:0]    data_o;

`ifdef SERIAL_SHIFT_LEFT_EN
    modport master (
        output start_i, arith_i, dir_i, data_i, shamt_i,
        input  busy_o, done_o, data_o
    );
    modport slave (
        input  start_i, arith_i, dir_i, data_i, shamt_i,
        output busy_o, done_o, data_o
    );
`else
    modport master (
        output start_i, arith_i, data_i, shamt_i,
        input  busy_o, done_o, data_o
    );
    modport slave (
        input  start_i, arith_i, data_i, shamt_i,
        output busy_o, done_o, data_o
    );
`endif

endinterface

// File: rtl/serial_shift_right_shift_step.sv
// Combinational single-bit shift step: right (sign or zero fill) or, with dir set, left.
// dir is only driven high by the top when SERIAL_SHIFT_LEFT_EN is defined.
module shift_step
    import serial_shift_right_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] i_data,
    input  logic            i_arith,
    input  logic            i_dir,
    output logic [size-1:0] o_data
);

    logic w_fill;

    always_comb begin
        w_fill = shift_fill(i_arith, i_data[size-1]);
        if (i_dir) begin
            o_data = {i_data[size-2:0], 1'b0};
        end else begin
            o_data = {w_fill, i_data[size-1:1]};
        end
    end

endmodule

// File: rtl/serial_shift_right.sv
// Multi-cycle shifter: one bit per clock, result held until the next accepted start.
// Define SERIAL_SHIFT_LEFT_EN to add the dir_i (shift left logical) option.
module serial_shift_right
    import serial_shift_right_pkg::*;
#(
    parameter int unsigned size    = SHIFT_SIZE_DEF,
    parameter int unsigned shamt_w = $clog2(size)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_shift_right_if.slave  bus
);

    shift_state_e       r_state;
    logic [size-1:0]    r_data;
    logic [shamt_w-1:0] r_cnt;
    logic               r_arith;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;

    logic [size-1:0]    w_step;
    logic               w_dir_in;

`ifdef SERIAL_SHIFT_LEFT_EN
    assign w_dir_in = bus.dir_i;
`else
    assign w_dir_in = 1'b0;
`endif

    shift_step #(
        .size (size)
    ) u_step (
        .i_data  (r_data),
        .i_arith (r_arith),
        .i_dir   (r_dir),
        .o_data  (w_step)
    );

    // IDLE and DONE both accept a start, giving back-to-back operation with no gap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_arith <= 1'b0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_data  <= bus.data_i;
                        r_cnt   <= bus.shamt_i;
                        r_arith <= bus.arith_i;
                        r_dir   <= w_dir_in;
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_data <= w_step;
                        r_cnt  <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.data_o = r_data;

endmodule

// File: tb/tb_serial_shift_right.sv
// Scoreboard bench for serial_shift_right; covers the left-shift option when
// SERIAL_SHIFT_LEFT_EN is defined.
module tb_serial_shift_right;

    localparam int unsigned SIZE = 32;
    localparam int unsigned SHW  = 5;
    localparam int unsigned MAX_WAIT = 40;

    typedef struct {
        logic [SIZE-1:0] data;
        int unsigned     lat;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;
    exp_t sb_q[$];

    serial_shift_right_if #(.size(SIZE), .shamt_w(SHW)) bus ();

    serial_shift_right #(.size(SIZE), .shamt_w(SHW)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SIZE-1:0] model(input logic [SIZE-1:0] d, input int unsigned sh,
                                              input logic ar, input logic dr);
        logic signed [SIZE-1:0] s;
        s = d;
        if (dr) return d << sh;
        if (ar) return s >>> sh;
        return d >> sh;
    endfunction

    // Drive a start at the current negedge; returns at the negedge just after the accepting edge.
    task automatic do_accept(input logic [SIZE-1:0] d, input logic [SHW-1:0] sh,
                             input logic ar, input logic dr, input bit push);
        exp_t e;
        bus.start_i = 1'b1;
        bus.data_i  = d;
        bus.shamt_i = sh;
        bus.arith_i = ar;
`ifdef SERIAL_SHIFT_LEFT_EN
        bus.dir_i   = dr;
`endif
        if (push) begin
            e.data = model(d, sh, ar, dr);
            e.lat  = int'(sh) + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_busy: busy_o=%b expected 1", bus.busy_o);
        end
    endtask

    // k counts clock edges after the accepting edge; called at k=0.
    task automatic wait_done(input string name);
        exp_t e;
        int unsigned k;
        bit seen;
        k = 0;
        seen = 0;
        while (!seen && k <= MAX_WAIT) begin
            if (bus.done_o === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, MAX_WAIT);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_done: done_o=1 with empty scoreboard", name);
            return;
        end
        e = sb_q.pop_front();
        if (k !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges, expected %0d", name, k, e.lat);
        end
        checks++;
        if (bus.data_o !== e.data) begin
            errors++;
            $display("FAIL %s_data: data_o=%h expected %h", name, bus.data_o, e.data);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: busy_o=%b expected 0", name, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: data_o=%h busy_o=%b done_o=%b expected 0/0/0",
                     bus.data_o, bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: data_o=%h busy_o=%b done_o=%b expected 0/0/0",
                     bus.data_o, bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_srl();
        do_accept(32'hF000_0000, 5'd4, 1'b0, 1'b0, 1);
        wait_done("srl");
        checks++;
        if (bus.data_o !== 32'h0F00_0000) begin
            errors++;
            $display("FAIL srl_const: data_o=%h expected 0f000000", bus.data_o);
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0 || bus.data_o !== 32'h0F00_0000) begin
            errors++;
            $display("FAIL srl_hold: done_o=%b data_o=%h expected 0/0f000000", bus.done_o, bus.data_o);
        end
    endtask

    task automatic test_sra();
        do_accept(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1);
        wait_done("sra");
        checks++;
        if (bus.data_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sra_const: data_o=%h expected ffffffff", bus.data_o);
        end
        @(negedge clk);
        do_accept(32'h8000_0000, 5'd31, 1'b0, 1'b0, 1);
        wait_done("srl31");
        @(negedge clk);
    endtask

    task automatic test_zero_shift();
        do_accept(32'h1234_5678, 5'd0, 1'b1, 1'b0, 1);
        checks++;
        @(negedge clk);
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_busy_one_cycle: busy_o=%b done_o=%b expected 0/1", bus.busy_o, bus.done_o);
        end
        sb_q[0].lat = 0;
        wait_done("zero");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_accept(32'hA5A5_0F0F, 5'd3, 1'b0, 1'b0, 1);
        // Hold start high with a new operand throughout the first shift.
        bus.start_i = 1'b1;
        bus.data_i  = 32'h8765_4321;
        bus.shamt_i = 5'd2;
        bus.arith_i = 1'b1;
        wait_done("b2b_first");
        e.data = model(32'h8765_4321, 2, 1'b1, 1'b0);
        e.lat  = 3;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: busy_o=%b done_o=%b expected 1/0", bus.busy_o, bus.done_o);
        end
        wait_done("b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        bit bad;
        do_accept(32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data_o=%h busy_o=%b done_o=%b expected 0/0/0",
                     bus.data_o, bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || bus.data_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_quiet: stray activity seen=%0d data_o=%h expected 0", bad, bus.data_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_accept($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 1);
            wait_done("rand");
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_SHIFT_LEFT_EN
    task automatic test_left();
        do_accept(32'h0000_0001, 5'd31, 1'b1, 1'b1, 1);
        wait_done("sll");
        checks++;
        if (bus.data_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sll_const: data_o=%h expected 80000000", bus.data_o);
        end
        @(negedge clk);
        do_accept(32'hF0F0_1234, 5'd7, 1'b0, 1'b1, 1);
        wait_done("sll7");
        @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.arith_i = 1'b0;
        bus.data_i  = '0;
        bus.shamt_i = '0;
`ifdef SERIAL_SHIFT_LEFT_EN
        bus.dir_i   = 1'b0;
`endif
        test_reset();
        test_srl();
        test_sra();
        test_zero_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
`ifdef SERIAL_SHIFT_LEFT_EN
        test_left();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
